ps2_key_event_rx: RTL and testbench
===================================

Name: ps2_key_event_rx

Overview:
Parametrised PS/2 keyboard receiver that turns raw device frames into decoded key events. Each event is {ext, brk, code}, with E0/F0 prefixes folded into flags. Events are buffered in a first-word-fall-through FIFO, and an interrupt is raised per accepted event. It replaces the single-scancode keyboard driver as the CPU-facing keyboard peripheral on the 100 MHz system clock, with no internal clock divider.

Parameters:
FILTER_LEN, 8, consecutive equal PS2CLK samples required to change the filtered clock level
FIFO_DEPTH, 8, event FIFO entries; power of 2, at least 2
INTR_CYCLES, 9, INTRPT high time in CLK cycles per accepted event
TIMEOUT_CYCLES, 100000, maximum CLK cycles between filtered falling edges inside a frame

Ports:
CLK  in  1  system clock, 100 MHz
reset  in  1  asynchronous, active-high
PS2CLK  in  1  raw PS/2 clock (asynchronous)
PS2DATA  in  1  raw PS/2 data (asynchronous)
RD  in  1  pop FIFO head; ignored when EVT_VALID=0
EVT_VALID  out  1  FIFO not empty
EVT_CODE  out  8  head event scancode
EVT_BRK  out  1  head event is a key release
EVT_EXT  out  1  head event is an extended (E0) key
FIFO_COUNT  out  $clog2(FIFO_DEPTH+1)  current number of entries
INTRPT  out  1  event interrupt pulse
ERR_PARITY  out  1  sticky parity or framing error
ERR_OVF  out  1  sticky FIFO overflow
ERR_CLR  in  1  one-cycle clear of both sticky errors

Interface: already decided — reset reset, asynchronous, active-high; clock CLK.

Behaviour:
- Reset values: all outputs 0, FIFO empty, all FSMs idle, filtered clock level 1.
- Input conditioning:
  - PS2CLK and PS2DATA each pass through a 2-flop synchroniser.
  - The filtered clock level changes only after FILTER_LEN identical synchronised samples.
  - Data is sampled on the filtered clock falling edge.
- Frame FSM states and transitions:
  - IDLE -> START on a falling edge with data=0. A falling edge with data=1 is ignored.
  - START/DATA shift in 8 bits, LSB first.
  - PARITY: odd parity over the 8 data bits plus the parity bit.
  - STOP: stop bit must be 1.
  - Good frame: byte_valid asserted for 1 cycle, then IDLE.
  - Parity failure or stop bit = 0: byte discarded, ERR_PARITY set, decoder forced to D_IDLE, frame FSM to IDLE.
- Timeout: in any non-IDLE frame state, more than TIMEOUT_CYCLES cycles with no falling edge returns the frame FSM to IDLE. Partial data is discarded silently, with no error flag.
- Decoder FSM:
  - States: D_IDLE, D_E0, D_F0, D_E0F0.
  - E0 from D_IDLE -> D_E0.
  - F0 from D_IDLE -> D_F0; F0 from D_E0 -> D_E0F0.
  - Any other byte pushes {ext, brk, code}, with ext/brk taken from the current state, then D_IDLE.
  - Bytes 00 and FF (device overrun) are discarded and return the decoder to D_IDLE.
- Latency: the event is visible at the FIFO head (or counted in FIFO_COUNT) 2 CLK cycles after the filtered stop-bit falling edge.
- FIFO behaviour:
  - First-word fall-through; the head is valid whenever EVT_VALID=1.
  - RD with EVT_VALID=1 pops at the next CLK edge.
  - Push while full, without a simultaneous pop: event dropped, ERR_OVF set, contents unchanged.
  - Simultaneous push and pop when full: both performed, count unchanged.
  - Simultaneous push and pop when empty: count becomes 1.
  - Pointers wrap modulo FIFO_DEPTH.
- INTRPT:
  - Asserted the cycle after each accepted push, held INTR_CYCLES cycles.
  - A push during an active pulse restarts the counter, extending the pulse.
  - Dropped pushes do not trigger INTRPT.
- ERR_CLR clears both sticky flags; a same-cycle error set wins over the clear.
- Reset mid-frame: asynchronous return to all reset values; the next complete frame is received normally.

Optional Feature:
PS2_TYPEMATIC_FILTER_EN
- Defined: a 9-bit register holds the last make {ext, code} and a held flag. A make event equal to the held key with held=1 is suppressed: no push and no INTRPT. A matching break clears held. Any other make replaces the register.
- Undefined: every typematic repeat is pushed as a separate make event.

Decomposition:
- Package ps2_pkg:
  - key_event_t packed struct {ext, brk, code[7:0]}
  - PS2_EXT=8'hE0, PS2_BRK=8'hF0, PS2_OVR0=8'h00, PS2_OVR1=8'hFF
  - frame and decoder state enums
- Sub-module ps2_frame_rx: synchroniser, filter, frame FSM, parity check, timeout. Outputs byte_valid, byte, frame_err.
- Decoder, optional typematic filter, FIFO and interrupt logic live in the top module.

Test Plan:
- Valid frame 0x1C -> EVT_VALID=1, CODE=1C, BRK=0, EXT=0, FIFO_COUNT=1; INTRPT high exactly 9 cycles.
- Frames E0,F0,75 -> exactly one event: CODE=75, EXT=1, BRK=1; one INTRPT pulse.
- F0 then 0x1C with bad parity, then valid 0x1C -> ERR_PARITY=1; one event CODE=1C, BRK=0 (prefix cleared). ERR_CLR -> ERR_PARITY=0.
- Nine make codes 0x01..0x09, RD=0 -> FIFO_COUNT=8, ERR_OVF=1; popping yields 01..08 in order, then EVT_VALID=0.
- PS2CLK stopped after 4 data bits for more than 100000 cycles, then valid 0x2A -> single event CODE=2A, ERR_PARITY=0.
- reset pulsed mid-frame -> all outputs 0; next 0x5A frame -> event CODE=5A. With PS2_TYPEMATIC_FILTER_EN, 1C,1C,1C,F0,1C -> exactly 2 events: make 1C, break 1C.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 key event receiver.
// Optional build macro: PS2_TYPEMATIC_FILTER_EN (see ps2_key_event_rx.sv).
package ps2_pkg;

  localparam logic [7:0] PS2_EXT  = 8'hE0;
  localparam logic [7:0] PS2_BRK  = 8'hF0;
  localparam logic [7:0] PS2_OVR0 = 8'h00;
  localparam logic [7:0] PS2_OVR1 = 8'hFF;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } key_event_t;

  // The start bit is consumed on the IDLE exit, so DATA also covers the
  // "start seen" phase of the frame.
  typedef enum logic [1:0] {F_IDLE, F_DATA, F_PARITY, F_STOP} frame_state_t;

  typedef enum logic [1:0] {D_IDLE, D_E0, D_F0, D_E0F0} dec_state_t;

  // Odd parity: data bits plus parity bit must hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: input synchronisers, clock glitch filter, 11-bit
// frame FSM with odd-parity/stop check and an inter-edge timeout.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       ps2clk_i,
  input  logic       ps2data_i,
  output logic       byte_valid_o,
  output logic [7:0] byte_o,
  output logic       frame_err_o
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic          filt_q, fall_q, fdat_q;
  logic [FW-1:0] fcnt_q;
  frame_state_t  st_q;
  logic [7:0]    sh_q, byte_q;
  logic [2:0]    bcnt_q;
  logic          par_ok_q, byte_valid_q, frame_err_q;
  logic [TW-1:0] tcnt_q;

  // Two-flop synchronisers; idle bus level is high on both lines.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
    end else begin
      clk_s1_q <= ps2clk_i;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= ps2data_i;
      dat_s2_q <= dat_s1_q;
    end
  end

  // Flip the filtered clock after FILTER_LEN consecutive differing samples;
  // capture data alongside the falling flip and pulse fall_q for one cycle.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      filt_q <= 1'b1;
      fcnt_q <= '0;
      fall_q <= 1'b0;
      fdat_q <= 1'b0;
    end else begin
      fall_q <= 1'b0;
      if (clk_s2_q == filt_q) begin
        fcnt_q <= '0;
      end else if (fcnt_q == FW'(FILTER_LEN - 1)) begin
        filt_q <= clk_s2_q;
        fcnt_q <= '0;
        fall_q <= filt_q;
        fdat_q <= dat_s2_q;
      end else begin
        fcnt_q <= fcnt_q + FW'(1);
      end
    end
  end

  // Frame FSM: start, 8 data bits LSB first, parity, stop; timeout aborts.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      st_q         <= F_IDLE;
      sh_q         <= '0;
      bcnt_q       <= '0;
      par_ok_q     <= 1'b0;
      tcnt_q       <= '0;
      byte_q       <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      if (st_q == F_IDLE || fall_q)         tcnt_q <= '0;
      else if (tcnt_q != TW'(TIMEOUT_CYCLES)) tcnt_q <= tcnt_q + TW'(1);
      case (st_q)
        F_IDLE: if (fall_q && !fdat_q) begin
          st_q   <= F_DATA;
          bcnt_q <= '0;
        end
        F_DATA: if (fall_q) begin
          sh_q   <= {fdat_q, sh_q[7:1]};
          bcnt_q <= bcnt_q + 3'd1;
          if (bcnt_q == 3'd7) st_q <= F_PARITY;
        end
        F_PARITY: if (fall_q) begin
          par_ok_q <= odd_parity_ok(sh_q, fdat_q);
          st_q     <= F_STOP;
        end
        F_STOP: if (fall_q) begin
          st_q <= F_IDLE;
          if (fdat_q && par_ok_q) begin
            byte_valid_q <= 1'b1;
            byte_q       <= sh_q;
          end else begin
            frame_err_q <= 1'b1;
          end
        end
        default: st_q <= F_IDLE;
      endcase
      // Silent abort: a stalled device leaves no error behind.
      if (st_q != F_IDLE && !fall_q && tcnt_q == TW'(TIMEOUT_CYCLES))
        st_q <= F_IDLE;
    end
  end

  assign byte_valid_o = byte_valid_q;
  assign byte_o       = byte_q;
  assign frame_err_o  = frame_err_q;

endmodule

// File: rtl/ps2_key_event_rx.sv
// PS/2 keyboard event receiver: prefix decoder (E0/F0 folded into flags),
// FWFT event FIFO, interrupt stretcher and sticky error flags.
// Optional build macro: PS2_TYPEMATIC_FILTER_EN suppresses auto-repeat makes.
module ps2_key_event_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int FIFO_DEPTH     = 8,
  parameter int INTR_CYCLES    = 9,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                              CLK,
  input  logic                              reset,
  input  logic                              PS2CLK,
  input  logic                              PS2DATA,
  input  logic                              RD,
  output logic                              EVT_VALID,
  output logic [7:0]                        EVT_CODE,
  output logic                              EVT_BRK,
  output logic                              EVT_EXT,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   FIFO_COUNT,
  output logic                              INTRPT,
  output logic                              ERR_PARITY,
  output logic                              ERR_OVF,
  input  logic                              ERR_CLR
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int IW = $clog2(INTR_CYCLES + 1);

  logic       rx_valid, rx_err;
  logic [7:0] rx_byte;

  ps2_frame_rx #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_frame (
    .CLK          (CLK),
    .reset        (reset),
    .ps2clk_i     (PS2CLK),
    .ps2data_i    (PS2DATA),
    .byte_valid_o (rx_valid),
    .byte_o       (rx_byte),
    .frame_err_o  (rx_err)
  );

  dec_state_t dec_q;
  key_event_t evt;
  logic       is_pfx, is_ovr, cand, suppress, push_req;

  // Candidate event from the current byte; flags come from the prefix state.
  always_comb begin
    evt.ext  = (dec_q == D_E0) || (dec_q == D_E0F0);
    evt.brk  = (dec_q == D_F0) || (dec_q == D_E0F0);
    evt.code = rx_byte;
    is_ovr   = (rx_byte == PS2_OVR0) || (rx_byte == PS2_OVR1);
    is_pfx   = ((rx_byte == PS2_EXT) && (dec_q == D_IDLE)) ||
               ((rx_byte == PS2_BRK) && ((dec_q == D_IDLE) || (dec_q == D_E0)));
    cand     = rx_valid && !is_ovr && !is_pfx;
  end

  // Prefix decoder; a bad frame drops any half-collected prefix.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      dec_q <= D_IDLE;
    end else if (rx_err) begin
      dec_q <= D_IDLE;
    end else if (rx_valid) begin
      if (is_ovr || !is_pfx)                         dec_q <= D_IDLE;
      else if (rx_byte == PS2_EXT)                   dec_q <= D_E0;
      else if (dec_q == D_E0)                        dec_q <= D_E0F0;
      else                                           dec_q <= D_F0;
    end
  end

`ifdef PS2_TYPEMATIC_FILTER_EN
  logic [8:0] held_key_q;
  logic       held_q;

  assign suppress = cand && !evt.brk && held_q && (held_key_q == {evt.ext, evt.code});

  // Remember the last make; its release re-arms the same key.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      held_key_q <= '0;
      held_q     <= 1'b0;
    end else if (cand) begin
      if (!evt.brk) begin
        held_key_q <= {evt.ext, evt.code};
        held_q     <= 1'b1;
      end else if (held_key_q == {evt.ext, evt.code}) begin
        held_q <= 1'b0;
      end
    end
  end
`else
  assign suppress = 1'b0;
`endif

  assign push_req = cand && !suppress;

  key_event_t    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic [IW-1:0] icnt_q;
  logic          pop, full, push_ok, ovf;
  logic          err_par_q, err_ovf_q;

  assign pop     = RD && (cnt_q != '0);
  assign full    = (cnt_q == CW'(FIFO_DEPTH));
  assign push_ok = push_req && (!full || pop);
  assign ovf     = push_req && full && !pop;

  // FWFT FIFO storage and pointers; power-of-2 depth lets pointers wrap freely.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_q] <= evt;
        wr_q        <= wr_q + PW'(1);
      end
      if (pop) rd_q <= rd_q + PW'(1);
      if (push_ok && !pop)      cnt_q <= cnt_q + CW'(1);
      else if (!push_ok && pop) cnt_q <= cnt_q - CW'(1);
    end
  end

  // Interrupt stretcher; each accepted push restarts the count.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset)                 icnt_q <= '0;
    else if (push_ok)          icnt_q <= IW'(INTR_CYCLES);
    else if (icnt_q != '0)     icnt_q <= icnt_q - IW'(1);
  end

  // Sticky errors; a set in the same cycle as the clear wins.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      err_par_q <= 1'b0;
      err_ovf_q <= 1'b0;
    end else begin
      if (rx_err)       err_par_q <= 1'b1;
      else if (ERR_CLR) err_par_q <= 1'b0;
      if (ovf)          err_ovf_q <= 1'b1;
      else if (ERR_CLR) err_ovf_q <= 1'b0;
    end
  end

  key_event_t head;
  assign head       = mem_q[rd_q];
  assign EVT_VALID  = (cnt_q != '0);
  assign EVT_CODE   = head.code;
  assign EVT_BRK    = head.brk;
  assign EVT_EXT    = head.ext;
  assign FIFO_COUNT = cnt_q;
  assign INTRPT     = (icnt_q != '0);
  assign ERR_PARITY = err_par_q;
  assign ERR_OVF    = err_ovf_q;

endmodule

// File: tb/tb_ps2_key_event_rx.sv
// Bench for ps2_key_event_rx: table-driven frame sequences plus hand-written
// parity, timeout, overflow, reset and typematic sequences; a queue holds
// expected events and is compared as the FIFO is drained.
module tb_ps2_key_event_rx;
  import ps2_pkg::*;

  logic       CLK = 1'b0;
  logic       reset, PS2CLK, PS2DATA, RD, ERR_CLR;
  logic       EVT_VALID, EVT_BRK, EVT_EXT, INTRPT, ERR_PARITY, ERR_OVF;
  logic [7:0] EVT_CODE;
  logic [3:0] FIFO_COUNT;

  always #5 CLK = ~CLK;

  ps2_key_event_rx #(.TIMEOUT_CYCLES(2000)) dut (
    .CLK        (CLK),
    .reset      (reset),
    .PS2CLK     (PS2CLK),
    .PS2DATA    (PS2DATA),
    .RD         (RD),
    .EVT_VALID  (EVT_VALID),
    .EVT_CODE   (EVT_CODE),
    .EVT_BRK    (EVT_BRK),
    .EVT_EXT    (EVT_EXT),
    .FIFO_COUNT (FIFO_COUNT),
    .INTRPT     (INTRPT),
    .ERR_PARITY (ERR_PARITY),
    .ERR_OVF    (ERR_OVF),
    .ERR_CLR    (ERR_CLR)
  );

  int         total = 0;
  int         bad   = 0;
  logic [9:0] sb [$];
  int         intr_hi = 0, intr_rise = 0;
  logic       intr_prev = 1'b0;

  // Interrupt pulse monitor.
  always @(posedge CLK) begin
    if (INTRPT) intr_hi <= intr_hi + 1;
    if (INTRPT && !intr_prev) intr_rise <= intr_rise + 1;
    intr_prev <= INTRPT;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Device-side frame: data set while clock high, ~40 CLK per bit.
  task automatic send_frame(input logic [7:0] b, input bit bad_par,
                            input bit bad_stop, input int nbits);
    logic [10:0] fr;
    fr = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      PS2DATA = fr[i];
      cyc(10);
      PS2CLK = 1'b0;
      cyc(20);
      PS2CLK = 1'b1;
      cyc(10);
    end
    PS2DATA = 1'b1;
    cyc(20);
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0, 11);
  endtask

  // Pop every event and compare against the scoreboard.
  task automatic drain();
    int g;
    g = 0;
    while (EVT_VALID && g < 12) begin
      logic [9:0] e;
      e = (sb.size() != 0) ? sb.pop_front() : 10'h3FF;
      chk("head_event", {EVT_EXT, EVT_BRK, EVT_CODE}, e);
      RD = 1'b1;
      cyc(1);
      RD = 1'b0;
      g++;
    end
    chk("sb_left", sb.size(), 0);
    chk("drained_valid", EVT_VALID, 0);
  endtask

  task automatic clr_err();
    ERR_CLR = 1'b1;
    cyc(1);
    ERR_CLR = 1'b0;
  endtask

  typedef struct {
    int              n;
    logic [2:0][7:0] b;
    int              nev;
    logic [9:0]      ev;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int r0, h0, exp_n;
    vecs[0] = '{1, {8'h00, 8'h00, 8'h1C}, 1, {2'b00, 8'h1C}};
    vecs[1] = '{3, {8'h75, 8'hF0, 8'hE0}, 1, {2'b11, 8'h75}};
    vecs[2] = '{2, {8'h00, 8'h6B, 8'hE0}, 1, {2'b10, 8'h6B}};
    vecs[3] = '{2, {8'h00, 8'h5A, 8'hF0}, 1, {2'b01, 8'h5A}};
    vecs[4] = '{1, {8'h00, 8'h00, 8'h00}, 0, 10'h000};
    vecs[5] = '{3, {8'h29, 8'hFF, 8'hF0}, 1, {2'b00, 8'h29}};
    vecs[6] = '{3, {8'h34, 8'h00, 8'hE0}, 1, {2'b00, 8'h34}};

    reset = 1'b1; PS2CLK = 1'b1; PS2DATA = 1'b1; RD = 1'b0; ERR_CLR = 1'b0;
    cyc(3);
    reset = 1'b0;
    cyc(2);
    chk("rst_valid", EVT_VALID, 0);
    chk("rst_count", FIFO_COUNT, 0);
    chk("rst_intr", INTRPT, 0);
    chk("rst_errp", ERR_PARITY, 0);
    chk("rst_erro", ERR_OVF, 0);

    // Table-driven prefix/decoder sequences.
    for (int v = 0; v < 7; v++) begin
      r0 = intr_rise; h0 = intr_hi;
      if (vecs[v].nev != 0) sb.push_back(vecs[v].ev);
      for (int f = 0; f < vecs[v].n; f++) send(vecs[v].b[f]);
      cyc(20);
      chk($sformatf("vec%0d_count", v), FIFO_COUNT, vecs[v].nev);
      chk($sformatf("vec%0d_intr_pulses", v), intr_rise - r0, vecs[v].nev);
      chk($sformatf("vec%0d_intr_len", v), intr_hi - h0, 9 * vecs[v].nev);
      drain();
    end

    // Bad parity after a break prefix: prefix discarded, error sticky.
    send(8'hF0);
    send_frame(8'h1C, 1'b1, 1'b0, 11);
    cyc(5);
    chk("par_err", ERR_PARITY, 1);
    chk("par_count", FIFO_COUNT, 0);
    sb.push_back({2'b00, 8'h1C});
    send(8'h1C);
    cyc(20);
    chk("par_next_count", FIFO_COUNT, 1);
    drain();
    clr_err();
    chk("par_clr", ERR_PARITY, 0);

    // Stop bit of 0 is a framing error.
    send_frame(8'h33, 1'b0, 1'b1, 11);
    cyc(5);
    chk("stop_err", ERR_PARITY, 1);
    chk("stop_count", FIFO_COUNT, 0);
    clr_err();

    // Clock stalls mid-frame; timeout must realign on the next frame.
    send_frame(8'h55, 1'b0, 1'b0, 5);
    cyc(2500);
    sb.push_back({2'b00, 8'h2A});
    send(8'h2A);
    cyc(20);
    chk("to_count", FIFO_COUNT, 1);
    chk("to_errp", ERR_PARITY, 0);
    drain();

    // Overflow: nine makes into an eight-entry FIFO.
    r0 = intr_rise;
    for (int i = 1; i <= 9; i++) begin
      if (i <= 8) sb.push_back({2'b00, 8'(i)});
      send(8'(i));
    end
    cyc(20);
    chk("ovf_count", FIFO_COUNT, 8);
    chk("ovf_flag", ERR_OVF, 1);
    chk("ovf_intr_pulses", intr_rise - r0, 8);
    drain();
    clr_err();
    chk("ovf_clr", ERR_OVF, 0);

    // Asynchronous reset mid-frame with state loaded.
    send_frame(8'h11, 1'b1, 1'b0, 11);
    send(8'h1C);
    send_frame(8'h5A, 1'b0, 1'b0, 4);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_valid", EVT_VALID, 0);
    chk("mid_rst_count", FIFO_COUNT, 0);
    chk("mid_rst_errp", ERR_PARITY, 0);
    chk("mid_rst_code", EVT_CODE, 0);
    cyc(3);
    reset = 1'b0;
    cyc(2);
    sb.push_back({2'b00, 8'h5A});
    send(8'h5A);
    cyc(20);
    chk("post_rst_count", FIFO_COUNT, 1);
    drain();

    // Typematic repeat handling.
`ifdef PS2_TYPEMATIC_FILTER_EN
    exp_n = 2;
    sb.push_back({2'b00, 8'h1C});
`else
    exp_n = 4;
    for (int i = 0; i < 3; i++) sb.push_back({2'b00, 8'h1C});
`endif
    sb.push_back({2'b01, 8'h1C});
    r0 = intr_rise;
    send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C);
    cyc(20);
    chk("typ_count", FIFO_COUNT, exp_n);
    chk("typ_intr_pulses", intr_rise - r0, exp_n);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
